sar_sample_seq: RTL and testbench
=================================

# sar_sample_seq

Conversion sequencer and averaging front-end for the SAR_ADC controller: it is the initiating end of the start/den/Dout handshake. It issues periodic one-cycle start pulses and captures each result on den. It averages 2^AVG_LOG2 results and presents the average to downstream logic on a valid/ready handshake. It flags dropped sample slots and conversions that never complete.

## Interface
- ADC_WIDTH, 8: result width of the attached SAR_ADC.
- AVG_LOG2, 2: log2 of samples per average; legal range 0..4.
- PERIOD, 32: clock cycles between sample slots; must be at least ADC_WIDTH+4.
- clk  in  1  system clock; all logic on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- en  in  1  enables sample-slot generation.
- clr  in  1  one-cycle pulse clearing the sticky flags.
- adc_start  out  1  one-cycle start pulse to SAR_ADC.
- adc_den  in  1  SAR_ADC result-valid strobe.
- adc_dout  in  ADC_WIDTH  SAR_ADC result, sampled when adc_den=1.
- avg_data  out  ADC_WIDTH  averaged result.
- avg_valid  out  1  avg_data valid.
- avg_ready  in  1  downstream accepts avg_data.
- busy  out  1  state is not IDLE.
- overrun  out  1  sticky: a sample slot was dropped.
- timeout_err  out  1  sticky: a conversion produced no adc_den.

## Operation
- Reset values (async): adc_start=0, avg_data=0, avg_valid=0, busy=0, overrun=0, timeout_err=0. Accumulator, sample count, period counter and timeout counter are all 0. State is IDLE.
- Period counter:
  - While en=1 it counts down from PERIOD-1; at 0 it asserts a one-cycle tick and reloads.
  - While en=0 it holds at PERIOD-1 and no tick is generated.
  - The first tick occurs PERIOD cycles after en rises.
- IDLE: on tick, go to WAIT; adc_start=1 for exactly the next cycle; timeout counter is loaded with 2*ADC_WIDTH+4.
- WAIT:
  - On adc_den=1: acc += adc_dout, zero-extended to ADC_WIDTH+AVG_LOG2 bits.
  - If this was sample 2^AVG_LOG2 of the set, go to HOLD; otherwise go to IDLE.
  - If the timeout counter reaches 0 before adc_den: set timeout_err and go to IDLE. The sample is not counted; acc and count are unchanged.
- Completing a set:
  - avg_data = (acc + new sample) >> AVG_LOG2, truncated.
  - avg_valid=1; acc and count are cleared.
- HOLD: avg_valid and avg_data stay stable until avg_valid&avg_ready; then go to IDLE with avg_valid=0.
- Overrun:
  - A tick arriving in WAIT or HOLD is dropped and sets overrun.
  - A tick arriving in the same cycle as the transition to IDLE is also dropped.
- Spurious adc_den: ignored in IDLE and HOLD.
- en falling: a conversion in progress completes normally; no new starts are issued.
- clr clears overrun and timeout_err. If a set condition and clr occur in the same cycle, the flag is set.
- Reset mid-operation: everything returns to reset values immediately; a partial average is discarded.

## Timing
- Tick at cycle t in IDLE: adc_start high at t+1, busy high from t+1.
- adc_den at cycle c completing a set: avg_valid and avg_data appear at c+1.
- adc_den at cycle c not completing a set: IDLE at c+1.
- avg_ready high in the cycle avg_valid is first high: avg_valid low the next cycle. Minimum valid width is 1 cycle.
- Timeout: with no adc_den, timeout_err rises 2*ADC_WIDTH+4 cycles after adc_start, i.e. cycle t+1+20 for ADC_WIDTH=8.
- adc_start is never high for two consecutive cycles.

## Test plan
- Average: defaults, en=1, avg_ready=1; SAR_ADC driven from analog values giving 0x10, 0x20, 0x30, 0x41 -> exactly one avg_valid pulse with avg_data=0x28 (161>>2), one cycle after the 4th den; 4 adc_start pulses spaced 32 cycles apart.
- Backpressure: avg_ready=0 after the first average -> avg_data held at 0x28; the next tick sets overrun with no adc_start issued; raising avg_ready then clears avg_valid the next cycle; clr clears overrun.
- Timeout: model never asserts adc_den -> timeout_err=1 20 cycles after adc_start; back to IDLE; the next slot starts normally; the later average uses only completed samples.
- AVG_LOG2=0, input 0xFF -> avg_data=0xFF one cycle after den; no overflow.
- en drop during WAIT -> conversion completes and is accumulated; no further adc_start while en=0; first start is PERIOD cycles after en returns.
- Reset mid-conversion: rst_n low during WAIT with 2 samples accumulated -> all outputs 0 immediately; after release, the first average uses 4 fresh samples only.

Source files
------------

// File: rtl/sar_sample_seq.sv
`default_nettype none
// ============================================================================
// Module   : sar_sample_seq
// Purpose  : Periodic SAR_ADC start sequencer with 2^AVG_LOG2 result averaging,
//            valid/ready output and sticky overrun / timeout flags.
// Revision : 1.0  initial release
// ============================================================================
module sar_sample_seq #(
    parameter int ADC_WIDTH = 8,
    parameter int AVG_LOG2  = 2,
    parameter int PERIOD    = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 en,
    input  logic                 clr,
    output logic                 adc_start,
    input  logic                 adc_den,
    input  logic [ADC_WIDTH-1:0] adc_dout,
    output logic [ADC_WIDTH-1:0] avg_data,
    output logic                 avg_valid,
    input  logic                 avg_ready,
    output logic                 busy,
    output logic                 overrun,
    output logic                 timeout_err
);

    localparam int c_PER_W    = (PERIOD > 2) ? $clog2(PERIOD) : 1;
    localparam int c_TMO_LOAD = 2 * ADC_WIDTH + 4;
    localparam int c_TMO_W    = $clog2(c_TMO_LOAD + 1);
    localparam int c_ACC_W    = ADC_WIDTH + AVG_LOG2;
    localparam int c_CNT_W    = AVG_LOG2 + 1;

    localparam logic [c_PER_W-1:0] c_PER_MAX = c_PER_W'(PERIOD - 1);
    localparam logic [c_TMO_W-1:0] c_TMO_INIT = c_TMO_W'(c_TMO_LOAD);
    localparam logic [c_CNT_W-1:0] c_LAST_SAMPLE = c_CNT_W'((1 << AVG_LOG2) - 1);

    localparam logic [1:0] c_ST_IDLE = 2'd0;
    localparam logic [1:0] c_ST_WAIT = 2'd1;
    localparam logic [1:0] c_ST_HOLD = 2'd2;

    logic [1:0]           r_state;
    logic [c_PER_W-1:0]   r_per_cnt;
    logic [c_TMO_W-1:0]   r_tmo_cnt;
    logic [c_ACC_W-1:0]   r_acc;
    logic [c_CNT_W-1:0]   r_cnt;
    logic                 r_start;
    logic [ADC_WIDTH-1:0] r_avg_data;
    logic                 r_avg_valid;
    logic                 r_overrun;
    logic                 r_timeout_err;

    logic                 w_tick;
    logic                 w_drop;
    logic                 w_tmo_expire;
    logic [c_ACC_W-1:0]   w_sum;

    assign w_tick       = en && (r_per_cnt == '0);
    // Any tick not seen in IDLE is lost, including one coinciding with the return to IDLE.
    assign w_drop       = w_tick && (r_state != c_ST_IDLE);
    assign w_tmo_expire = (r_state == c_ST_WAIT) && !adc_den && (r_tmo_cnt == c_TMO_W'(1));
    assign w_sum        = r_acc + c_ACC_W'(adc_dout);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_per_cnt <= '0;
        end else if (!en || (r_per_cnt == '0)) begin
            r_per_cnt <= c_PER_MAX;
        end else begin
            r_per_cnt <= r_per_cnt - c_PER_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= c_ST_IDLE;
            r_tmo_cnt   <= '0;
            r_acc       <= '0;
            r_cnt       <= '0;
            r_start     <= 1'b0;
            r_avg_data  <= '0;
            r_avg_valid <= 1'b0;
        end else begin
            r_start <= 1'b0;
            case (r_state)
                c_ST_IDLE: begin
                    if (w_tick) begin
                        r_state   <= c_ST_WAIT;
                        r_start   <= 1'b1;
                        r_tmo_cnt <= c_TMO_INIT;
                    end
                end
                c_ST_WAIT: begin
                    if (adc_den) begin
                        if (r_cnt == c_LAST_SAMPLE) begin
                            r_avg_data  <= w_sum[c_ACC_W-1:AVG_LOG2];
                            r_avg_valid <= 1'b1;
                            r_acc       <= '0;
                            r_cnt       <= '0;
                            r_state     <= c_ST_HOLD;
                        end else begin
                            r_acc   <= w_sum;
                            r_cnt   <= r_cnt + c_CNT_W'(1);
                            r_state <= c_ST_IDLE;
                        end
                    end else if (w_tmo_expire) begin
                        // Abandoned conversion: the slot is lost but the partial set is kept.
                        r_tmo_cnt <= '0;
                        r_state   <= c_ST_IDLE;
                    end else begin
                        r_tmo_cnt <= r_tmo_cnt - c_TMO_W'(1);
                    end
                end
                c_ST_HOLD: begin
                    if (avg_ready) begin
                        r_avg_valid <= 1'b0;
                        r_state     <= c_ST_IDLE;
                    end
                end
                default: begin
                    r_state <= c_ST_IDLE;
                end
            endcase
        end
    end

    // Sticky flags: a set event wins over a simultaneous clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_overrun     <= 1'b0;
            r_timeout_err <= 1'b0;
        end else begin
            r_overrun     <= (r_overrun & ~clr) | w_drop;
            r_timeout_err <= (r_timeout_err & ~clr) | w_tmo_expire;
        end
    end

    assign adc_start   = r_start;
    assign avg_data    = r_avg_data;
    assign avg_valid   = r_avg_valid;
    assign busy        = (r_state != c_ST_IDLE);
    assign overrun     = r_overrun;
    assign timeout_err = r_timeout_err;

endmodule
`default_nettype wire

// File: tb/tb_sar_sample_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_sar_sample_seq
// Purpose  : Scoreboard bench for sar_sample_seq with random SAR_ADC responders.
// Revision : 1.0  initial release
// ============================================================================
module tb_sar_sample_seq;

    localparam int W  = 8;
    localparam int L  = 2;
    localparam int P  = 32;
    localparam int PB = 16;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       en = 1'b0;
    logic       en_b = 1'b0;
    logic       clr = 1'b0;

    logic       adc_start, avg_valid, busy, overrun, timeout_err;
    logic       adc_den = 1'b0;
    logic [7:0] adc_dout = 8'h00;
    logic [7:0] avg_data;
    logic       avg_ready = 1'b1;

    logic       adc_start_b, avg_valid_b, busy_b, overrun_b, timeout_err_b;
    logic       adc_den_b = 1'b0;
    logic [7:0] adc_dout_b = 8'h00;
    logic [7:0] avg_data_b;
    logic       avg_ready_b = 1'b1;

    sar_sample_seq #(.ADC_WIDTH(W), .AVG_LOG2(L), .PERIOD(P)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .clr(clr),
        .adc_start(adc_start), .adc_den(adc_den), .adc_dout(adc_dout),
        .avg_data(avg_data), .avg_valid(avg_valid), .avg_ready(avg_ready),
        .busy(busy), .overrun(overrun), .timeout_err(timeout_err)
    );

    sar_sample_seq #(.ADC_WIDTH(W), .AVG_LOG2(0), .PERIOD(PB)) dut_b (
        .clk(clk), .rst_n(rst_n), .en(en_b), .clr(clr),
        .adc_start(adc_start_b), .adc_den(adc_den_b), .adc_dout(adc_dout_b),
        .avg_data(avg_data_b), .avg_valid(avg_valid_b), .avg_ready(avg_ready_b),
        .busy(busy_b), .overrun(overrun_b), .timeout_err(timeout_err_b)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_pass = 0;
    int epoch = 0;
    bit silent = 1'b0;
    int start_cnt = 0;
    int n_avg_a = 0;
    int n_avg_b = 0;
    int sam_a[$];
    int exp_a[$];
    int exp_b[$];
    logic [7:0] forced_a[$];
    logic [7:0] forced_b[$];

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    endtask

    task automatic fail_bound(input string name);
        n_checks++;
        $display("FAIL %s: got no event within bound, expected one (cycle %0d)", name, cyc);
    endtask

    // Reference: every accepted result joins the current set; a full set yields floor(sum / 2^L).
    function automatic void model_a(input int d);
        int sum;
        sam_a.push_back(d);
        if (sam_a.size() == (1 << L)) begin
            sum = 0;
            foreach (sam_a[i]) sum += sam_a[i];
            exp_a.push_back(sum / (1 << L));
            sam_a.delete();
        end
    endfunction

    // SAR_ADC model for the averaging instance; optionally stays silent for one conversion.
    initial forever begin
        @(posedge clk); #1;
        if (rst_n && adc_start) begin : resp_a
            int my_ep;
            int lat;
            logic [7:0] d;
            if (silent) begin
                silent = 1'b0;
            end else begin
                my_ep = epoch;
                lat = $urandom_range(2, 16);
                d = (forced_a.size() != 0) ? forced_a.pop_front() : 8'($urandom);
                repeat (lat - 1) begin @(posedge clk); #1; end
                if (rst_n && epoch == my_ep) begin
                    adc_den = 1'b1; adc_dout = d; model_a(int'(d));
                    @(posedge clk); #1;
                    adc_den = 1'b0;
                end
            end
        end
    end

    initial forever begin
        @(posedge clk); #1;
        if (rst_n && adc_start_b) begin : resp_b
            int my_ep;
            int lat;
            logic [7:0] d;
            my_ep = epoch;
            lat = $urandom_range(2, 16);
            d = (forced_b.size() != 0) ? forced_b.pop_front() : 8'($urandom);
            repeat (lat - 1) begin @(posedge clk); #1; end
            if (rst_n && epoch == my_ep) begin
                adc_den_b = 1'b1; adc_dout_b = d; exp_b.push_back(int'(d));
                @(posedge clk); #1;
                adc_den_b = 1'b0;
            end
        end
    end

    logic pv_a = 1'b0, pd_a = 1'b0, ps_a = 1'b0;
    logic pv_b = 1'b0, pd_b = 1'b0, ps_b = 1'b0;
    int held_a = 0, held_b = 0;

    always @(negedge clk) begin
        if (!rst_n) begin
            pv_a = 1'b0; pd_a = 1'b0; ps_a = 1'b0;
        end else begin
            if (adc_start) begin
                start_cnt++;
                check("start_single_cycle", int'(ps_a), 0);
            end
            if (avg_valid && !pv_a) begin
                n_avg_a++;
                if (exp_a.size() == 0) fail_bound("avg_unexpected");
                else begin
                    held_a = exp_a.pop_front();
                    check("avg_data", int'(avg_data), held_a);
                end
                check("avg_latency_after_den", int'(pd_a), 1);
            end else if (avg_valid) begin
                check("avg_data_held", int'(avg_data), held_a);
            end
            pv_a = avg_valid; pd_a = adc_den; ps_a = adc_start;
        end
    end

    always @(negedge clk) begin
        if (!rst_n) begin
            pv_b = 1'b0; pd_b = 1'b0; ps_b = 1'b0;
        end else begin
            if (adc_start_b) check("b_start_single_cycle", int'(ps_b), 0);
            if (avg_valid_b && !pv_b) begin
                n_avg_b++;
                if (exp_b.size() == 0) fail_bound("b_avg_unexpected");
                else begin
                    held_b = exp_b.pop_front();
                    check("b_avg_data", int'(avg_data_b), held_b);
                end
                check("b_avg_latency_after_den", int'(pd_b), 1);
            end else if (avg_valid_b) begin
                check("b_avg_data_held", int'(avg_data_b), held_b);
            end
            pv_b = avg_valid_b; pd_b = adc_den_b; ps_b = adc_start_b;
        end
    end

    task automatic wait_start(output int t);
        for (int i = 0; i < 400; i++) begin
            @(negedge clk); #1;
            if (adc_start) begin
                t = cyc;
                return;
            end
        end
        fail_bound("wait_adc_start");
        t = -1;
    endtask

    task automatic wait_avg(input int target);
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk); #1;
            if (n_avg_a >= target) return;
        end
        fail_bound("wait_avg_valid");
    endtask

    task automatic pulse_clr();
        @(posedge clk); #1; clr = 1'b1;
        @(posedge clk); #1; clr = 1'b0;
    endtask

    initial begin : main
        int e, t, tp, s, tt, sc;
        bit found;
        repeat (3) @(posedge clk);
        #1;
        check("rst_adc_start", int'(adc_start), 0);
        check("rst_avg_data", int'(avg_data), 0);
        check("rst_avg_valid", int'(avg_valid), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_overrun", int'(overrun), 0);
        check("rst_timeout_err", int'(timeout_err), 0);
        check("rst_b_avg_valid", int'(avg_valid_b), 0);
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        // Known average 0x10,0x20,0x30,0x41 -> 0x28; full-scale pass-through on the 1-sample instance.
        forced_a = '{8'h10, 8'h20, 8'h30, 8'h41};
        forced_b = '{8'hFF, 8'hFF};
        en = 1'b1; en_b = 1'b1; e = cyc;
        wait_start(t);
        check("first_start_delay", t - e, P);
        for (int i = 1; i < 4; i++) begin
            tp = t;
            wait_start(t);
            check("start_spacing", t - tp, P);
        end
        wait_avg(1);
        check("avg_valid_first", int'(avg_valid), 1);
        check("avg_first_0x28", int'(avg_data), 8'h28);

        // Random samples under random backpressure.
        tt = n_avg_a + 3;
        for (int i = 0; i < 4000 && n_avg_a < tt; i++) begin
            @(posedge clk); #1;
            avg_ready = 1'($urandom_range(0, 1));
        end
        if (n_avg_a < tt) fail_bound("random_backpressure_avgs");
        avg_ready = 1'b1;

        pulse_clr();
        check("clr_overrun_initial", int'(overrun), 0);
        check("no_timeout_yet", int'(timeout_err), 0);

        // Held output, dropped slot, ignored spurious den.
        avg_ready = 1'b0;
        wait_avg(n_avg_a + 1);
        sc = start_cnt;
        @(posedge clk); #1; adc_den = 1'b1; adc_dout = 8'($urandom);
        @(posedge clk); #1; adc_den = 1'b0;
        repeat (40) @(posedge clk);
        #1;
        check("overrun_set_in_hold", int'(overrun), 1);
        check("no_start_in_hold", start_cnt, sc);
        check("valid_held", int'(avg_valid), 1);
        avg_ready = 1'b1;
        @(posedge clk); #1;
        check("valid_drop_after_ready", int'(avg_valid), 0);
        check("idle_after_ready", int'(busy), 0);
        pulse_clr();
        check("clr_overrun", int'(overrun), 0);

        // Silent conversion times out; next slot still on schedule.
        wait_start(t);
        silent = 1'b1;
        wait_start(s);
        tt = -1;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk); #1;
            if (timeout_err) begin
                tt = cyc;
                break;
            end
        end
        check("timeout_delay", tt - s, 2 * W + 4);
        check("idle_after_timeout", int'(busy), 0);
        wait_start(t);
        check("slot_after_timeout", t - s, P);
        pulse_clr();
        check("clr_timeout", int'(timeout_err), 0);

        // en dropped mid-conversion.
        wait_start(t);
        @(posedge clk); #1; en = 1'b0;
        sc = start_cnt;
        repeat (100) @(posedge clk);
        #1;
        check("no_start_while_en_low", start_cnt, sc);
        en = 1'b1; e = cyc;
        wait_start(t);
        check("restart_delay", t - e, P);

        // Reset while waiting on the third sample of a set.
        found = 1'b0;
        for (int i = 0; i < 12 && !found; i++) begin
            wait_start(t);
            if (sam_a.size() == 2) found = 1'b1;
        end
        if (!found) fail_bound("find_two_sample_partial");
        #1;
        rst_n = 1'b0;
        epoch++;
        sam_a.delete(); exp_a.delete(); exp_b.delete();
        #1;
        check("midrst_adc_start", int'(adc_start), 0);
        check("midrst_busy", int'(busy), 0);
        check("midrst_avg_valid", int'(avg_valid), 0);
        check("midrst_avg_data", int'(avg_data), 0);
        check("midrst_overrun", int'(overrun), 0);
        check("midrst_timeout_err", int'(timeout_err), 0);
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        wait_avg(n_avg_a + 2);

        en = 1'b0; en_b = 1'b0;
        repeat (60) @(posedge clk);
        #1;
        check("drain_a", exp_a.size(), 0);
        check("drain_b", exp_b.size(), 0);
        check("b_outputs_seen", int'(n_avg_b > 10), 1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_watchdog: simulation still running at cycle %0d, expected finish", cyc);
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
